display_mux_7seg: RTL and testbench
===================================

Name: display_mux_7seg

Overview:
- Downstream consumer of the 4-bit counter output. Takes the binary count 0..15 and shows it in decimal on two multiplexed 7-segment digits: tens and units.
- Registers the input, converts binary to tens/units, and time-multiplexes the digit anodes with a refresh divider.
- Updates the displayed value only at frame boundaries, so a digit pair never mixes two counts.

Parameters:
- DIV_WIDTH, 2: refresh divider width; each digit slot lasts 2^DIV_WIDTH clk cycles; a frame is 2*2^DIV_WIDTH cycles.
- ACTIVE_LOW, 1: 1 inverts seg and an (common-anode board); 0 makes them active-high.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- q  input  4  binary count from the counter stage, 0..15.
- seg  output  7  segment drive, seg[6:0] = g,f,e,d,c,b,a (seg[0]=a).
- an  output  2  digit enable, an[0]=units, an[1]=tens.
- frame_tick  output  1  one-cycle pulse in the last cycle of each frame.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- Registers:
  - q_reg (4 bits): captures q every cycle.
  - div (DIV_WIDTH bits): increments every cycle and wraps from all-ones to 0.
  - state: UNIDADE or DEZENA.
  - shown_val (4 bits).
- Reset (rst=1 at an edge): q_reg=0, div=0, state=UNIDADE, shown_val=0.
  - Outputs during and after reset: an selects units, seg shows "0", frame_tick=0.
  - Reset asserted mid-frame has the same effect on the next edge. No partial frame is completed.
- FSM:
  - UNIDADE -> DEZENA when div is all-ones.
  - DEZENA -> UNIDADE when div is all-ones.
  - No other transitions.
- frame_tick: combinational; equals (state==DEZENA && div all-ones).
  - On that same edge, shown_val <= q_reg.
- Latency:
  - q sampled at edge n appears in q_reg after edge n.
  - It is displayed from the edge that ends the next frame.
  - Worst case: 1 + 2*2^DIV_WIDTH cycles.
- Conversion (combinational from shown_val only):
  - tens = (shown_val >= 10) ? 1 : 0.
  - units = shown_val - 10*tens, 4-bit result, always 0..9.
- Segment codes, active-high gfedcba:
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66
  - 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F
  - Unreachable codes drive blank (0x00).
- Digit selection:
  - UNIDADE: an active on [0], seg = code(units).
  - DEZENA: an active on [1], seg = code(tens), or blank per the optional feature.
  - Exactly one an bit is active at any time; never both, never none.
- ACTIVE_LOW=1: seg and an are bitwise inverted after selection. Blank = 0x7F; units active = an 2'b10.
- seg and an depend only on registered state and shown_val. There is no combinational path from q.
- Wrap-around: input 15 -> 0 needs no special handling; 15 shows "15", then 0 shows "0" or "00".

Optional Feature:
- Macro: ZERO_BLANK_EN.
- Defined: in DEZENA, when tens==0, seg is blank (all segments off) and an[1] stays active, so the slot timing is unchanged.
- Not defined: the tens digit always shows its code; tens==0 shows "0" (0x3F, or 0x40 active-low).

Test Plan:
- Reset, default params, ZERO_BLANK_EN defined, q=0, rst=1 for 2 cycles then 0:
  - During reset and immediately after: an=2'b10, seg=0x40.
  - frame_tick high in the 8th cycle after rst release (div=3, DEZENA), then every 8 cycles.
- q=7 held for 2 frames:
  - After the following frame_tick, units slot: an=2'b10, seg=0x78.
  - Tens slot: an=2'b01, seg=0x7F.
  - Same test with the macro undefined: tens seg=0x40.
- q=13 held: units seg=0x30, tens seg=0x79.
- q=5 displayed, q changed to 9 mid-frame:
  - Both slots keep showing 5 (units 0x12) until the frame_tick edge.
  - Units then shows 0x10; no frame ever mixes old and new values.
- Counter wrap, q stepping 14, 15, 0, each held one frame:
  - Shows "14" (units 0x19, tens 0x79), then "15" (units 0x12), then "0" (units 0x40, tens blank).
  - Check that exactly one an bit is low in every cycle.
- rst pulsed for 1 cycle during a DEZENA slot while showing 13:
  - Next cycle: an=2'b10, seg=0x40, div=0.
  - Next frame_tick 8 cycles after release; display then shows 13 again.

Source files
------------

// File: rtl/display_mux_7seg.sv
// Two-digit multiplexed 7-segment display for a 0..15 binary count (tens/units).
// Optional ZERO_BLANK_EN blanks a leading zero in the tens slot.
module display_mux_7seg #(
    parameter int DIV_WIDTH  = 2,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] q,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       frame_tick
);

    typedef enum logic {
        UNIDADE = 1'b0,
        DEZENA  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [3:0]           q_reg_q;
    logic [3:0]           shown_q, shown_d;

    logic       div_last;
    logic       tens;
    logic [3:0] units;
    logic [6:0] seg_raw;
    logic [1:0] an_raw;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'h3F;
            4'd1:    seg_code = 7'h06;
            4'd2:    seg_code = 7'h5B;
            4'd3:    seg_code = 7'h4F;
            4'd4:    seg_code = 7'h66;
            4'd5:    seg_code = 7'h6D;
            4'd6:    seg_code = 7'h7D;
            4'd7:    seg_code = 7'h07;
            4'd8:    seg_code = 7'h7F;
            4'd9:    seg_code = 7'h6F;
            default: seg_code = 7'h00;
        endcase
    endfunction

    assign div_last   = &div_q;
    assign frame_tick = (state_q == DEZENA) && div_last;

    always_comb begin
        div_d   = div_q + DIV_WIDTH'(1);
        state_d = state_q;
        if (div_last) begin
            state_d = (state_q == UNIDADE) ? DEZENA : UNIDADE;
        end
        // The displayed value only changes at the frame boundary so a digit pair never mixes counts.
        shown_d = frame_tick ? q_reg_q : shown_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= UNIDADE;
            div_q   <= '0;
            q_reg_q <= 4'd0;
            shown_q <= 4'd0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            q_reg_q <= q;
            shown_q <= shown_d;
        end
    end

    assign tens  = (shown_q >= 4'd10);
    assign units = tens ? (shown_q - 4'd10) : shown_q;

    always_comb begin
        an_raw  = 2'b01;
        seg_raw = seg_code(units);
        if (state_q == DEZENA) begin
            an_raw  = 2'b10;
            seg_raw = seg_code({3'b000, tens});
`ifdef ZERO_BLANK_EN
            if (!tens) begin
                seg_raw = 7'h00;
            end
`else
`endif
        end
    end

    assign seg = ACTIVE_LOW ? ~seg_raw : seg_raw;
    assign an  = ACTIVE_LOW ? ~an_raw  : an_raw;

endmodule

// File: tb/tb_display_mux_7seg.sv
// Self-checking bench for display_mux_7seg: arithmetic reference model plus directed literal checks.
module tb_display_mux_7seg;

    localparam int DIV_WIDTH  = 2;
    localparam bit ACTIVE_LOW = 1'b1;
    localparam int SLOT       = 1 << DIV_WIDTH;
    localparam int FRAME      = 2 * SLOT;

`ifdef ZERO_BLANK_EN
    localparam logic [7:0] TENS0_SEG = 8'h7F;
`else
    localparam logic [7:0] TENS0_SEG = 8'h40;
`endif

    logic       clk;
    logic       rst;
    logic [3:0] q;
    logic [6:0] seg;
    logic [1:0] an;
    logic       frame_tick;

    int checks = 0;
    int errors = 0;

    display_mux_7seg #(
        .DIV_WIDTH (DIV_WIDTH),
        .ACTIVE_LOW(ACTIVE_LOW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .q         (q),
        .seg       (seg),
        .an        (an),
        .frame_tick(frame_tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: t counts edges since the last reset edge; slots and frames follow by division.
    logic [6:0] codes [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    int   t = 0;
    int   m_qreg = 0;
    int   m_shown = 0;
    bit   model_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            t = 0;
            m_qreg = 0;
            m_shown = 0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            if ((t % FRAME) == FRAME - 1) m_shown = m_qreg;
            m_qreg = int'(q);
            t = t + 1;
        end
    end

    always @(negedge clk) begin
        logic [6:0] e_seg;
        logic [1:0] e_an;
        logic       e_tick;
        if (model_valid) begin
            if (((t / SLOT) % 2) == 0) begin
                e_an  = 2'b01;
                e_seg = codes[m_shown % 10];
            end else begin
                e_an  = 2'b10;
                e_seg = codes[m_shown / 10];
`ifdef ZERO_BLANK_EN
                if ((m_shown / 10) == 0) e_seg = 7'h00;
`endif
            end
            if (ACTIVE_LOW) begin
                e_seg = ~e_seg;
                e_an  = ~e_an;
            end
            e_tick = ((t % FRAME) == FRAME - 1);
            chk("model_seg", {1'b0, seg}, {1'b0, e_seg});
            chk("model_an", {6'b0, an}, {6'b0, e_an});
            chk("model_tick", {7'b0, frame_tick}, {7'b0, e_tick});
            chk("an_onehot", {7'b0, (an == 2'b01 || an == 2'b10)}, 8'h01);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_tick();
        int k;
        k = 0;
        while (frame_tick !== 1'b1 && k < 64) begin
            @(negedge clk);
            k++;
        end
        if (frame_tick !== 1'b1) chk("tick_timeout", 8'h00, 8'h01);
    endtask

    // Ends at the first units cycle of the frame displaying v.
    task automatic show(input logic [3:0] v);
        q = v;
        step(1);
        wait_tick();
        step(1);
    endtask

    task automatic count_to_tick(input string name);
        int cnt;
        cnt = 0;
        while (frame_tick !== 1'b1 && cnt < 64) begin
            @(negedge clk);
            cnt++;
        end
        chk(name, 8'(cnt), 8'd7);
    endtask

    initial begin
        rst = 1'b1;
        q   = 4'd0;
        step(1);
        chk("rst_an", {6'b0, an}, 8'h02);
        chk("rst_seg", {1'b0, seg}, 8'h40);
        chk("rst_tick", {7'b0, frame_tick}, 8'h00);
        step(1);
        rst = 1'b0;
        chk("post_rst_seg", {1'b0, seg}, 8'h40);
        count_to_tick("first_tick_cycle");
        step(FRAME);
        chk("tick_period", {7'b0, frame_tick}, 8'h01);

        show(4'd7);
        chk("q7_units_an", {6'b0, an}, 8'h02);
        chk("q7_units_seg", {1'b0, seg}, 8'h78);
        step(SLOT);
        chk("q7_tens_an", {6'b0, an}, 8'h01);
        chk("q7_tens_seg", {1'b0, seg}, TENS0_SEG);

        show(4'd13);
        chk("q13_units_seg", {1'b0, seg}, 8'h30);
        step(SLOT);
        chk("q13_tens_seg", {1'b0, seg}, 8'h79);

        show(4'd5);
        step(2);
        q = 4'd9;
        chk("mid_units_old", {1'b0, seg}, 8'h12);
        step(SLOT);
        chk("mid_tens_old", {1'b0, seg}, TENS0_SEG);
        wait_tick();
        step(1);
        chk("mid_units_new", {1'b0, seg}, 8'h10);

        show(4'd14);
        chk("q14_units_seg", {1'b0, seg}, 8'h19);
        step(SLOT);
        chk("q14_tens_seg", {1'b0, seg}, 8'h79);
        show(4'd15);
        chk("q15_units_seg", {1'b0, seg}, 8'h12);
        step(SLOT);
        chk("q15_tens_seg", {1'b0, seg}, 8'h79);
        show(4'd0);
        chk("q0_units_seg", {1'b0, seg}, 8'h40);
        step(SLOT);
        chk("q0_tens_seg", {1'b0, seg}, TENS0_SEG);

        show(4'd13);
        step(SLOT + 1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("midrst_an", {6'b0, an}, 8'h02);
        chk("midrst_seg", {1'b0, seg}, 8'h40);
        count_to_tick("midrst_tick_cycle");
        step(1);
        chk("midrst_units_seg", {1'b0, seg}, 8'h30);
        step(SLOT);
        chk("midrst_tens_seg", {1'b0, seg}, 8'h79);

        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
